// File: rtl/button_event_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// button_event_arbiter_pkg: shared event kinds, hold phases and counter sizing
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package button_event_arbiter_pkg;

  typedef enum logic {
    EVT_PRESS  = 1'b0,
    EVT_REPEAT = 1'b1
  } evt_kind_t;

  typedef enum logic [1:0] {
    PH_IDLE      = 2'd0,
    PH_WAIT_HOLD = 2'd1,
    PH_REPEATING = 2'd2
  } hold_phase_t;

  // Width able to hold the largest terminal count without wrapping.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_event_arbiter_cond.sv
// ---------------------------------------------------------------------------
// btn_conditioner: per-button debounce plus hold/auto-repeat tick generation
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btn_conditioner
  import button_event_arbiter_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 20,
  parameter int HOLD_CNT     = 500,
  parameter int REPEAT_CNT   = 150
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic btn,
  output logic db_level,
  output logic press_tick,
  output logic repeat_tick
);

  localparam int CW = cnt_width(DEBOUNCE_CNT, HOLD_CNT, REPEAT_CNT);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CNT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CNT - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CNT - 1);

  logic [CW-1:0] db_cnt, db_cnt_nxt;
  logic [CW-1:0] hold_cnt, hold_cnt_nxt;
  logic          db_nxt, press_nxt, repeat_nxt;
  hold_phase_t   phase, phase_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt      <= '0;
      db_level    <= 1'b0;
      hold_cnt    <= '0;
      phase       <= PH_IDLE;
      press_tick  <= 1'b0;
      repeat_tick <= 1'b0;
    end else begin
      db_cnt      <= db_cnt_nxt;
      db_level    <= db_nxt;
      hold_cnt    <= hold_cnt_nxt;
      phase       <= phase_nxt;
      press_tick  <= press_nxt;
      repeat_tick <= repeat_nxt;
    end
  end

  always_comb begin
    db_cnt_nxt   = db_cnt;
    db_nxt       = db_level;
    hold_cnt_nxt = hold_cnt;
    phase_nxt    = phase;
    press_nxt    = 1'b0;
    repeat_nxt   = 1'b0;
    if (sample_en) begin
      if (btn != db_level) begin
        if (db_cnt == DB_LAST) begin
          db_nxt     = btn;
          db_cnt_nxt = '0;
        end else begin
          db_cnt_nxt = db_cnt + 1'b1;
        end
      end else begin
        db_cnt_nxt = '0;
      end

      // The strobe that flips the debounced level never also counts as hold time.
      if (db_nxt != db_level) begin
        hold_cnt_nxt = '0;
        if (db_nxt) begin
          press_nxt = 1'b1;
          phase_nxt = PH_WAIT_HOLD;
        end else begin
          phase_nxt = PH_IDLE;
        end
      end else if (db_level) begin
        case (phase)
          PH_WAIT_HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              repeat_nxt   = 1'b1;
              hold_cnt_nxt = '0;
              phase_nxt    = PH_REPEATING;
            end else begin
              hold_cnt_nxt = hold_cnt + 1'b1;
            end
          end
          PH_REPEATING: begin
            if (hold_cnt == REP_LAST) begin
              repeat_nxt   = 1'b1;
              hold_cnt_nxt = '0;
            end else begin
              hold_cnt_nxt = hold_cnt + 1'b1;
            end
          end
          default: hold_cnt_nxt = '0;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/button_event_arbiter.sv
// ---------------------------------------------------------------------------
// button_event_arbiter: per-button press/repeat events, round-robin onto one valid/ready stream
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module button_event_arbiter
  import button_event_arbiter_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int DEBOUNCE_CNT = 20,
  parameter int HOLD_CNT     = 500,
  parameter int REPEAT_CNT   = 150,
  localparam int IW          = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [N_BTN-1:0] btn,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IW-1:0]    evt_id,
  output logic             evt_repeat,
  output logic [N_BTN-1:0] db_level,
  output logic             overflow
);

  logic [N_BTN-1:0] press_tick, repeat_tick;
  logic [N_BTN-1:0] pend, pend_nxt;
  evt_kind_t        kind     [N_BTN];
  evt_kind_t        kind_nxt [N_BTN];
  logic [IW-1:0]    rr_ptr, winner, idx;
  logic             found, grant, ovf_set;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_conditioner #(
      .DEBOUNCE_CNT (DEBOUNCE_CNT),
      .HOLD_CNT     (HOLD_CNT),
      .REPEAT_CNT   (REPEAT_CNT)
    ) u_cond (
      .clk         (clk),
      .rst         (rst),
      .sample_en   (sample_en),
      .btn         (btn[i]),
      .db_level    (db_level[i]),
      .press_tick  (press_tick[i]),
      .repeat_tick (repeat_tick[i])
    );
  end

  // Round-robin search begins just after the most recently granted button.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr;
    idx    = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      idx = IW'((int'(rr_ptr) + k) % N_BTN);
      if (!found && pend[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    grant = found && (!evt_valid || evt_ready);
  end

  // A new tick beats a same-edge grant, so the fresh event survives the clear.
  always_comb begin
    pend_nxt = pend;
    kind_nxt = kind;
    ovf_set  = 1'b0;
    if (grant) pend_nxt[winner] = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (press_tick[i]) begin
        if (pend[i] && !(grant && winner == IW'(i))) ovf_set = 1'b1;
        pend_nxt[i] = 1'b1;
        kind_nxt[i] = EVT_PRESS;
      end else if (repeat_tick[i]) begin
        if (pend[i] && !(grant && winner == IW'(i))) begin
          ovf_set = 1'b1;
        end else begin
          pend_nxt[i] = 1'b1;
          kind_nxt[i] = EVT_REPEAT;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend       <= '0;
      for (int i = 0; i < N_BTN; i++) kind[i] <= EVT_PRESS;
      rr_ptr     <= IW'(N_BTN - 1);
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      evt_repeat <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      pend <= pend_nxt;
      kind <= kind_nxt;
      if (ovf_set) overflow <= 1'b1;
      if (grant) begin
        evt_valid  <= 1'b1;
        evt_id     <= winner;
        evt_repeat <= (kind[winner] == EVT_REPEAT);
        rr_ptr     <= winner;
      end else if (evt_ready) begin
        evt_valid  <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_button_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_button_event_arbiter: scenario tasks checked against a strobe-level event model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_button_event_arbiter;

  localparam int N    = 4;
  localparam int DB   = 4;
  localparam int HOLD = 8;
  localparam int REP  = 3;
  localparam int IW   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_en;
  logic [N-1:0]  btn;
  logic          evt_ready;
  logic          evt_valid;
  logic [IW-1:0] evt_id;
  logic          evt_repeat;
  logic [N-1:0]  db_level;
  logic          overflow;

  always #5 clk = ~clk;

  button_event_arbiter #(
    .N_BTN(N), .DEBOUNCE_CNT(DB), .HOLD_CNT(HOLD), .REPEAT_CNT(REP)
  ) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .btn(btn),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_repeat(evt_repeat), .db_level(db_level), .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobes = 0;

  // Model: run lengths of disagreeing samples, strobes held since press, pending flags.
  logic [N-1:0] mdb, mpend, mkind;
  int  run [N];
  int  held [N];
  int  mtick [N];
  logic mvalid, mrep, movf;
  int  mid, mlast;

  logic [IW:0] acc_q[$];
  logic [IW:0] exp_q[$];
  int          acc_cyc[$];
  int          acc_str[$];

  wire [8:0] dut_vec = {evt_valid, evt_id, evt_repeat, db_level, overflow};

  function automatic logic [8:0] model_vec();
    return {mvalid, IW'(mid), mrep, mdb, movf};
  endfunction

  task automatic model_reset();
    mvalid = 1'b0; mid = 0; mrep = 1'b0; movf = 1'b0;
    mdb = '0; mpend = '0; mkind = '0; mlast = N - 1;
    for (int i = 0; i < N; i++) begin run[i] = 0; held[i] = 0; mtick[i] = 0; end
  endtask

  task automatic model_edge();
    int  win;
    bit  grant, old, taken, flipped;
    win = -1;
    if (!mvalid || evt_ready)
      for (int k = 1; k <= N; k++)
        if (win < 0 && mpend[(mlast + k) % N]) win = (mlast + k) % N;
    grant = (win >= 0);
    if (mvalid && evt_ready) exp_q.push_back({IW'(mid), mrep});
    if (grant) begin
      mvalid = 1'b1; mid = win; mrep = mkind[win]; mlast = win;
    end else if (evt_ready) begin
      mvalid = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      old   = mpend[i];
      taken = grant && (win == i);
      if (taken) mpend[i] = 1'b0;
      if (mtick[i] == 1) begin
        if (old && !taken) movf = 1'b1;
        mpend[i] = 1'b1; mkind[i] = 1'b0;
      end else if (mtick[i] == 2) begin
        if (old && !taken) movf = 1'b1;
        else begin mpend[i] = 1'b1; mkind[i] = 1'b1; end
      end
      mtick[i] = 0;
    end
    if (sample_en) begin
      strobes++;
      for (int i = 0; i < N; i++) begin
        flipped = 1'b0;
        if (btn[i] != mdb[i]) begin
          run[i]++;
          if (run[i] == DB) begin
            mdb[i] = btn[i]; run[i] = 0; flipped = 1'b1;
            if (mdb[i]) begin mtick[i] = 1; held[i] = 0; end
          end
        end else begin
          run[i] = 0;
        end
        if (mdb[i] && !flipped) begin
          held[i]++;
          if (held[i] >= HOLD && (held[i] - HOLD) % REP == 0) mtick[i] = 2;
        end
      end
    end
  endtask

  // One clock: log accepted events, advance model, then settle 1 time unit past the edge.
  task automatic step();
    if (!rst && evt_valid && evt_ready) begin
      acc_q.push_back({evt_id, evt_repeat});
      acc_cyc.push_back(cyc);
      acc_str.push_back(strobes);
    end
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    cyc++;
    sample_en = (cyc % 4 == 0);
  endtask

  task automatic clear_logs();
    acc_q.delete(); exp_q.delete(); acc_cyc.delete(); acc_str.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = '0; evt_ready = 1'b1; sample_en = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (dut_vec !== 9'b0) begin
      errors++; $display("FAIL reset_values dut=%b expected=%b", dut_vec, 9'b0);
    end
    rst = 1'b0;
    repeat (12) begin
      step();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL reset_idle t=%0t dut=%b model=%b", $time, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_simultaneous();
    for (int pass = 0; pass < 2; pass++) begin
      clear_logs();
      btn[0] = 1'b1; btn[3] = 1'b1;
      repeat (40) begin
        step();
        checks++;
        if (dut_vec !== model_vec()) begin
          errors++; $display("FAIL simul_cycle t=%0t dut=%b model=%b", $time, dut_vec, model_vec());
        end
      end
      checks++;
      if (acc_q.size() != 2 || acc_q[0] !== {2'd0, 1'b0} || acc_q[1] !== {2'd3, 1'b0}
          || acc_cyc[1] - acc_cyc[0] != 1) begin
        errors++;
        $display("FAIL simul_order pass=%0d got n=%0d first=%b second=%b expected id0 then id3 consecutive",
                 pass, acc_q.size(), acc_q.size() > 0 ? acc_q[0] : 3'bx, acc_q.size() > 1 ? acc_q[1] : 3'bx);
      end
      btn[0] = 1'b0; btn[3] = 1'b0;
      repeat (40) begin
        step();
        checks++;
        if (dut_vec !== model_vec()) begin
          errors++; $display("FAIL simul_release t=%0t dut=%b model=%b", $time, dut_vec, model_vec());
        end
      end
    end
  endtask

  task automatic test_bounce();
    int pat, last_low, rise_cyc, valid_cyc, g;
    clear_logs();
    pat = int'($urandom_range(0, 7));
    last_low = strobes;
    for (int s = 0; s < 3; s++) begin
      btn[1] = pat[s];
      repeat (4) begin
        step();
        checks++;
        if (dut_vec !== model_vec()) begin
          errors++; $display("FAIL bounce_cycle t=%0t dut=%b model=%b", $time, dut_vec, model_vec());
        end
      end
      if (!pat[s]) last_low = strobes;
    end
    btn[1] = 1'b1;
    g = 0;
    while (!db_level[1] && g < 200) begin
      step(); g++;
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL bounce_cycle t=%0t dut=%b model=%b", $time, dut_vec, model_vec());
      end
    end
    rise_cyc = cyc;
    checks++;
    if (g >= 200 || strobes - last_low != DB) begin
      errors++; $display("FAIL bounce_db_rise strobes_after_low=%0d expected=%0d", strobes - last_low, DB);
    end
    g = 0;
    while (!evt_valid && g < 20) begin step(); g++; end
    valid_cyc = cyc;
    checks++;
    if (valid_cyc - rise_cyc != 2) begin
      errors++; $display("FAIL bounce_latency cycles=%0d expected=2", valid_cyc - rise_cyc);
    end
    btn[1] = 1'b0;
    repeat (40) begin
      step();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL bounce_cycle t=%0t dut=%b model=%b", $time, dut_vec, model_vec());
      end
    end
    checks++;
    if (acc_q.size() != 1 || acc_q[0] !== {2'd1, 1'b0}) begin
      errors++; $display("FAIL bounce_events got n=%0d expected one press id=1", acc_q.size());
    end
  endtask

  task automatic test_hold();
    int g, base;
    int offs [6] = '{0, 8, 11, 14, 17, 20};
    clear_logs();
    btn[2] = 1'b1;
    g = 0;
    while (!db_level[2] && g < 200) begin
      step(); g++;
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL hold_cycle t=%0t dut=%b model=%b", $time, dut_vec, model_vec());
      end
    end
    base = strobes;
    while (strobes < base + 17) begin
      step();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL hold_cycle t=%0t dut=%b model=%b", $time, dut_vec, model_vec());
      end
    end
    btn[2] = 1'b0;
    repeat (80) begin
      step();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL hold_cycle t=%0t dut=%b model=%b", $time, dut_vec, model_vec());
      end
    end
    checks++;
    if (acc_q.size() != 6) begin
      errors++; $display("FAIL hold_count got=%0d expected=6", acc_q.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (acc_q[k] !== {2'd2, (k != 0)} || acc_str[k] - base != offs[k]) begin
          errors++;
          $display("FAIL hold_event k=%0d got=%b at_strobe=%0d expected=%b at_strobe=%0d",
                   k, acc_q[k], acc_str[k] - base, {2'd2, (k != 0)}, offs[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int base;
    bit seen;
    clear_logs();
    evt_ready = 1'b0;
    btn[2] = 1'b1;
    seen = 1'b0;
    base = strobes;
    while (strobes < base + 40) begin
      step();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL bp_cycle t=%0t dut=%b model=%b", $time, dut_vec, model_vec());
      end
      if (evt_valid) seen = 1'b1;
      if (seen) begin
        checks++;
        if ({evt_valid, evt_id, evt_repeat} !== {1'b1, 2'd2, 1'b0}) begin
          errors++; $display("FAIL bp_stable got=%b expected=%b", {evt_valid, evt_id, evt_repeat}, 4'b1100);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL bp_overflow got=%b expected=1", overflow);
    end
    evt_ready = 1'b1;
    btn[2] = 1'b0;
    repeat (60) begin
      step();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL bp_drain t=%0t dut=%b model=%b", $time, dut_vec, model_vec());
      end
    end
    checks++;
    if (acc_q.size() < 2 || acc_q[0] !== {2'd2, 1'b0} || acc_q[1] !== {2'd2, 1'b1}
        || acc_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_order got n=%0d expected n=%0d press then repeat", acc_q.size(), exp_q.size());
    end
  endtask

  task automatic test_random();
    clear_logs();
    for (int c = 0; c < 3000; c++) begin
      if (cyc % 4 == 1)
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 5) == 0) btn[i] = ~btn[i];
      evt_ready = ($urandom_range(0, 3) != 0);
      step();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL rand_cycle t=%0t dut=%b model=%b", $time, dut_vec, model_vec());
      end
    end
    btn = '0; evt_ready = 1'b1;
    repeat (80) step();
    checks++;
    if (acc_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count got=%0d expected=%0d", acc_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < acc_q.size(); k++) begin
        checks++;
        if (acc_q[k] !== exp_q[k]) begin
          errors++; $display("FAIL rand_event k=%0d got=%b expected=%b", k, acc_q[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int g, base, rise_cyc;
    clear_logs();
    btn[0] = 1'b1; evt_ready = 1'b0;
    g = 0;
    while (!evt_valid && g < 100) begin step(); g++; end
    checks++;
    if (g >= 100) begin errors++; $display("FAIL rmid_setup evt_valid never rose"); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dut_vec !== 9'b0) begin
      errors++; $display("FAIL rmid_async dut=%b expected=%b", dut_vec, 9'b0);
    end
    model_reset();
    step(); step();
    rst = 1'b0;
    evt_ready = 1'b1;
    base = strobes;
    g = 0;
    while (!db_level[0] && g < 100) begin
      step(); g++;
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL rmid_cycle t=%0t dut=%b model=%b", $time, dut_vec, model_vec());
      end
    end
    rise_cyc = cyc;
    checks++;
    if (g >= 100 || strobes - base != DB) begin
      errors++; $display("FAIL rmid_redebounce strobes=%0d expected=%0d", strobes - base, DB);
    end
    g = 0;
    while (!evt_valid && g < 20) begin step(); g++; end
    checks++;
    if (cyc - rise_cyc != 2 || evt_id !== 2'd0 || evt_repeat !== 1'b0) begin
      errors++; $display("FAIL rmid_press latency=%0d id=%0d rep=%b expected 2/0/0", cyc - rise_cyc, evt_id, evt_repeat);
    end
    btn[0] = 1'b0;
    repeat (30) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not terminate");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_simultaneous();
    test_bounce();
    test_hold();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/button_event_arbiter.md
# button_event_arbiter

Front-end controller for the clock's setting buttons: debounces N raw button levels, turns each debounced press into a single event, generates auto-repeat events while a button is held, and arbitrates all per-button events onto one valid/ready event stream. The time-set / alarm-set FSM is the only consumer. It replaces ad-hoc per-button edge detection so that simultaneous presses are never lost or merged.

## Interface
- N_BTN, 4 — number of buttons; must be ≥2.
- DEBOUNCE_CNT, 20 — consecutive sample strobes of a changed level required to accept the new level.
- HOLD_CNT, 500 — sample strobes a button must stay high, after the press event, before the first repeat event.
- REPEAT_CNT, 150 — sample strobes between subsequent repeat events.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sample_en  in  1  one-cycle debounce/hold time-base strobe, 1 kHz nominal.
- btn  in  N_BTN  raw button levels, already synchronised to clk, active-high.
- evt_valid  out  1  event present on evt_id/evt_repeat.
- evt_ready  in  1  consumer accepts the event when evt_valid & evt_ready.
- evt_id  out  $clog2(N_BTN)  index of the button that produced the event.
- evt_repeat  out  1  0 = press event, 1 = auto-repeat event.
- db_level  out  N_BTN  debounced levels.
- overflow  out  1  sticky; set when a pending event is overwritten or dropped.

## Operation
- Debounce, per button: on each sample_en, if btn[i] ≠ db_level[i] the counter increments, else it clears. On the strobe where the counter reaches DEBOUNCE_CNT, db_level[i] flips and the counter clears. Without sample_en nothing changes.
- Press: the cycle in which db_level[i] goes 0→1 sets pend[i]=1, kind[i]=press, and clears the hold counter. Falling debounced edges produce no event.
- Hold/repeat, per button: while db_level[i]=1, the hold counter increments on each sample_en. The first repeat fires when the count reaches HOLD_CNT; thereafter a repeat fires every REPEAT_CNT strobes. A repeat sets pend[i]=1, kind[i]=repeat. Release clears the counter and the phase.
- Pending conflicts:
  - A repeat while pend[i]=1 is dropped and sets overflow.
  - A press while pend[i]=1 overwrites kind to press and sets overflow.
- Arbiter: round-robin over pend. The search starts at the index after the last granted button; the reset pointer is N_BTN-1, so button 0 is searched first.
- Output register: a grant occurs when the register is empty (evt_valid=0) or being accepted this cycle (evt_valid & evt_ready), and some pend bit is set. On a grant, evt_id/evt_repeat load from the winner and its pend bit clears on the same edge.
- A pend set and a grant for the same button on the same edge: the set wins, so the new event is kept and overflow is not set.
- Handshake rules:
  - evt_valid, once high, holds until accepted.
  - evt_id and evt_repeat are stable while evt_valid=1 & evt_ready=0.
  - Back-to-back acceptance sustains one event per cycle.
- Width rules:
  - Counters are sized $clog2(max(DEBOUNCE_CNT, HOLD_CNT, REPEAT_CNT)+1).
  - A counter never wraps; it clears at its terminal count.

## Timing
- Reset values (asynchronous): evt_valid=0, evt_id=0, evt_repeat=0, db_level=0, overflow=0; all pend bits, debounce/hold counters and repeat phases clear; RR pointer=N_BTN-1.
- Latency: with the output idle, evt_valid rises 2 cycles after the clock edge that sets db_level[i] (edge sets pend, next edge loads the output).
- rst mid-handshake: an undelivered event is discarded. After reset, a still-held button must re-debounce (DEBOUNCE_CNT strobes) and then produces a press event.
- evt_ready is ignored while evt_valid=0.

## Structure
- Shared package:
  - evt_kind_t (PRESS=0, REPEAT=1).
  - Hold phase encoding (IDLE, WAIT_HOLD, REPEATING).
  - Counter-width function.
- Sub-module btn_conditioner: one instance per button via generate. It holds the debounce counter, db_level, and the hold FSM (IDLE → WAIT_HOLD on press; WAIT_HOLD → REPEATING at HOLD_CNT; any → IDLE on release). It emits one-cycle press_tick and repeat_tick.
- The top level holds the pend/kind registers, the round-robin arbiter, the output register and overflow.

## Test plan
Bench parameters: DEBOUNCE_CNT=4, HOLD_CNT=8, REPEAT_CNT=3, sample_en every 4 clocks, evt_ready=1 unless stated.
- Bounce: btn[1] toggles on strobes 1–3 then stays high → exactly one event, id=1, repeat=0; db_level[1] rises on the 4th stable strobe; evt_valid rises 2 cycles later.
- Hold: btn[2] held for 20 strobes after debounce → press, then repeats at strobe counts 8, 11, 14, 17, 20; no further events after release.
- Simultaneous: btn[0] and btn[3] debounce on the same edge → two consecutive events, id=0 then id=3; next simultaneous pair → id=0 before id=3 again (pointer at 3).
- Backpressure: evt_ready=0 for 40 strobes while btn[2] is held → first event is stable throughout; repeats are dropped and overflow=1; after evt_ready=1, delivery resumes in order.
- Reset mid-event: assert rst while evt_valid=1 with btn[0] held → all outputs 0 immediately; after release of rst, a new press for id=0 appears after 4 strobes + 2 cycles.
